// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the HI/LO multiply/divide unit.
//   - Funct field encodings for the R-type ops the unit decodes.
//   - state_t: FSM states (IDLE, MUL, DIV, FIX).
//   - op_class_t: decoded operation class (NONE, MF, MT, MUL, DIV).
package muldiv_pkg;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        OPC_NONE = 3'd0,
        OPC_MF   = 3'd1,
        OPC_MT   = 3'd2,
        OPC_MUL  = 3'd3,
        OPC_DIV  = 3'd4
    } op_class_t;

endpackage

// File: rtl/muldiv_core.sv
// muldiv_core: radix-2 iterative datapath for the HI/LO unit.
//   Multiply: shift-add, multiplier shifts out of acc_lo LSB-first while the
//   partial product shifts in from acc_hi. Divide: restoring shift-subtract,
//   dividend shifts out of acc_lo MSB-first, quotient bits shift in.
//   Operands are held as magnitudes; sign correction is applied to the
//   res_hi/res_lo outputs, which the owner samples during its FIX cycle.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   load              latch operands/sign flags, clear counter
//   signed_op         treat operands as two's complement (mult/div)
//   div_op            divide rather than multiply
//   step              perform one iteration
//   rs_data, rt_data  operands
//   last_step         the current step is the WIDTH-th
//   res_hi, res_lo    sign-corrected HI/LO result
// Build option: MULDIV_DIV_EN enables the divide datapath.
module muldiv_core
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             signed_op,
    input  logic             div_op,
    input  logic             step,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             last_step,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH-1:0]   mag;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [CNT_W-1:0]   cnt;
    logic               neg_q;
    logic [WIDTH:0]     add_sum;
    logic [2*WIDTH-1:0] prod;

    assign sign_a = signed_op & rs_data[WIDTH-1];
    assign sign_b = signed_op & rt_data[WIDTH-1];
    assign mag_a  = sign_a ? -rs_data : rs_data;
    assign mag_b  = sign_b ? -rt_data : rt_data;

    assign add_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag} : {(WIDTH+1){1'b0}});
    assign last_step = (cnt == CNT_W'(WIDTH - 1));
    assign prod      = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};

`ifdef MULDIV_DIV_EN
    logic           is_div;
    logic           neg_r;
    logic           b_zero;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           ge;

    // The partial remainder is always below the divisor, so WIDTH+1 bits
    // hold the shifted value and bit WIDTH of the difference is the borrow.
    assign shifted = {acc_hi, acc_lo[WIDTH-1]};
    assign diff    = shifted - {1'b0, mag};
    assign ge      = ~diff[WIDTH];
`else
    logic unused_div_op;
    assign unused_div_op = div_op;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            mag    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            cnt    <= '0;
            neg_q  <= 1'b0;
`ifdef MULDIV_DIV_EN
            is_div <= 1'b0;
            neg_r  <= 1'b0;
            b_zero <= 1'b0;
`endif
        end else if (load) begin
            cnt    <= '0;
            acc_hi <= '0;
            neg_q  <= sign_a ^ sign_b;
`ifdef MULDIV_DIV_EN
            is_div <= div_op;
            neg_r  <= sign_a;
            b_zero <= (rt_data == '0);
            acc_lo <= div_op ? mag_a : mag_b;
            mag    <= div_op ? mag_b : mag_a;
`else
            acc_lo <= mag_b;
            mag    <= mag_a;
`endif
        end else if (step) begin
            cnt <= cnt + CNT_W'(1);
`ifdef MULDIV_DIV_EN
            if (is_div) begin
                acc_hi <= ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
                acc_lo <= {acc_lo[WIDTH-2:0], ge};
            end else begin
                acc_hi <= add_sum[WIDTH:1];
                acc_lo <= {add_sum[0], acc_lo[WIDTH-1:1]};
            end
`else
            acc_hi <= add_sum[WIDTH:1];
            acc_lo <= {add_sum[0], acc_lo[WIDTH-1:1]};
`endif
        end
    end

`ifdef MULDIV_DIV_EN
    // Divide by zero leaves the dividend magnitude in the remainder, which
    // the remainder sign rule turns back into rs_data; only LO is forced.
    always_comb begin
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        if (is_div) begin
            res_hi = neg_r ? -acc_hi : acc_hi;
            res_lo = b_zero ? {WIDTH{1'b1}} : (neg_q ? -acc_lo : acc_lo);
        end
    end
`else
    assign res_hi = prod[2*WIDTH-1:WIDTH];
    assign res_lo = prod[WIDTH-1:0];
`endif

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle HI/LO multiply/divide execution unit.
//   Decodes mult/multu/div/divu/mfhi/mthi/mflo/mtlo (OpCode == 0), owns the
//   HI/LO registers, sequences muldiv_core and stalls the execute stage.
// Handshake: op_valid presents an instruction; stall is the inverse of ready.
//   A decoded op is accepted on the first rising edge where op_valid is high
//   and stall is low; its operands are sampled on that edge. Undecoded
//   instructions never stall.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   op_valid            execute-stage instruction valid
//   OpCode, Funct       instruction fields
//   rs_data, rt_data    operands
//   stall               hold the execute stage this cycle
//   busy                iterative operation in flight (MUL/DIV/FIX)
//   hilo_rdata          mfhi/mflo read data, 0 otherwise
//   dbg_state           current FSM state (state_t encoding)
// Build option: MULDIV_DIV_EN enables div/divu and the DIV state.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [5:0]       OpCode,
    input  logic [5:0]       Funct,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             stall,
    output logic             busy,
    output logic [WIDTH-1:0] hilo_rdata,
    output logic [1:0]       dbg_state
);

    state_t           state;
    state_t           state_next;
    op_class_t        op_class;
    logic             decoded;
    logic             start;
    logic             mt_we;
    logic             core_step;
    logic             fix_we;
    logic             last_step;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    always_comb begin
        op_class = OPC_NONE;
        if (OpCode == 6'd0) begin
            case (Funct)
                F_MFHI, F_MFLO:  op_class = OPC_MF;
                F_MTHI, F_MTLO:  op_class = OPC_MT;
                F_MULT, F_MULTU: op_class = OPC_MUL;
`ifdef MULDIV_DIV_EN
                F_DIV, F_DIVU:   op_class = OPC_DIV;
`endif
                default:         op_class = OPC_NONE;
            endcase
        end
    end

    assign decoded   = op_valid && (op_class != OPC_NONE);
    assign busy      = (state != S_IDLE);
    assign stall     = decoded && busy;
    assign start     = decoded && !busy && ((op_class == OPC_MUL) || (op_class == OPC_DIV));
    assign mt_we     = decoded && !busy && (op_class == OPC_MT);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        core_step  = 1'b0;
        fix_we     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = (op_class == OPC_DIV) ? S_DIV : S_MUL;
                end
            end
            S_MUL: begin
                core_step = 1'b1;
                if (last_step) begin
                    state_next = S_FIX;
                end
            end
`ifdef MULDIV_DIV_EN
            S_DIV: begin
                core_step = 1'b1;
                if (last_step) begin
                    state_next = S_FIX;
                end
            end
`endif
            S_FIX: begin
                fix_we     = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    muldiv_core #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .load      (start),
        .signed_op (~Funct[0]),
        .div_op    (op_class == OPC_DIV),
        .step      (core_step),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .last_step (last_step),
        .res_hi    (res_hi),
        .res_lo    (res_lo)
    );

    // FIX and mt writes are exclusive: mt is only accepted when not busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (fix_we) begin
            hi <= res_hi;
            lo <= res_lo;
        end else if (mt_we) begin
            if (Funct == F_MTHI) begin
                hi <= rs_data;
            end else begin
                lo <= rs_data;
            end
        end
    end

    assign hilo_rdata = (decoded && (op_class == OPC_MF)) ? ((Funct == F_MFHI) ? hi : lo) : '0;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  localparam int W = 32;
  localparam logic [5:0] T_MFHI  = 6'h10;
  localparam logic [5:0] T_MTHI  = 6'h11;
  localparam logic [5:0] T_MFLO  = 6'h12;
  localparam logic [5:0] T_MTLO  = 6'h13;
  localparam logic [5:0] T_MULT  = 6'h18;
  localparam logic [5:0] T_MULTU = 6'h19;
  localparam logic [5:0] T_DIV   = 6'h1A;
  localparam logic [5:0] T_DIVU  = 6'h1B;
  localparam logic [5:0] T_ADD   = 6'h20;

  logic         clk = 1'b0;
  logic         reset;
  logic         op_valid;
  logic [5:0]   opcode;
  logic [5:0]   funct;
  logic [W-1:0] rs;
  logic [W-1:0] rt;
  logic         stall;
  logic         busy;
  logic [W-1:0] hilo_rdata;
  logic [1:0]   dbg_state;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .op_valid   (op_valid),
    .OpCode     (opcode),
    .Funct      (funct),
    .rs_data    (rs),
    .rt_data    (rt),
    .stall      (stall),
    .busy       (busy),
    .hilo_rdata (hilo_rdata),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model + scoreboard ----------------
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;
  int           busy_until = 0;
  logic [W-1:0] rd_q[$];
  int           stall_q[$];
  int           busy_q[$];
  int           checks = 0;
  int           errors = 0;

  task automatic check32(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit is_start_op(input logic [5:0] f);
`ifdef MULDIV_DIV_EN
    return (f == T_MULT) || (f == T_MULTU) || (f == T_DIV) || (f == T_DIVU);
`else
    return (f == T_MULT) || (f == T_MULTU);
`endif
  endfunction

  function automatic bit tb_decoded(input logic [5:0] o, input logic [5:0] f);
    if (o != 6'd0) return 1'b0;
    return (f == T_MFHI) || (f == T_MTHI) || (f == T_MFLO) || (f == T_MTLO) || is_start_op(f);
  endfunction

  // Architectural result of a mult/div, straight from the ISA rules.
  task automatic model_apply(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    int          sa;
    int          sb;
    longint      sp;
    logic [63:0] up;
    sa = a;
    sb = b;
    case (f)
      T_MULT: begin
        sp = longint'(sa) * longint'(sb);
        {m_hi, m_lo} = sp;
      end
      T_MULTU: begin
        up = 64'(a) * 64'(b);
        {m_hi, m_lo} = up;
      end
      T_DIV: begin
        if (b == 0) begin
          m_lo = '1;
          m_hi = a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          m_lo = a;
          m_hi = '0;
        end else begin
          m_lo = sa / sb;
          m_hi = sa % sb;
        end
      end
      T_DIVU: begin
        if (b == 0) begin
          m_lo = '1;
          m_hi = a;
        end else begin
          m_lo = a / b;
          m_hi = a % b;
        end
      end
      default: ;
    endcase
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      op_valid = 1'b0;
      opcode   = '0;
      funct    = '0;
    end
  endtask

  task automatic issue(input logic [5:0] o, input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    int cur;
    int s;
    int n;
    bit dec;
    @(negedge clk);
    op_valid = 1'b1;
    opcode   = o;
    funct    = f;
    rs       = a;
    rt       = b;
    cur      = cyc;
    dec      = tb_decoded(o, f);
    s        = 0;
    if (dec) begin
      s = busy_until - cur;
      if (s < 0) s = 0;
      stall_q.push_back(s);
      if (f == T_MFHI) rd_q.push_back(m_hi);
      if (f == T_MFLO) rd_q.push_back(m_lo);
    end
    #1;
    n = 0;
    while (stall && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: stall held %0d cycles, required release within 200", n);
    end
    if (dec) begin
      if (f == T_MTHI) m_hi = a;
      if (f == T_MTLO) m_lo = a;
      if (is_start_op(f)) begin
        model_apply(f, a, b);
        busy_until = cur + s + W + 2;
        busy_q.push_back(W + 1);
      end
    end
    @(posedge clk);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset    = 1'b1;
    op_valid = 1'b0;
    opcode   = '0;
    funct    = '0;
    rs       = '0;
    rt       = '0;
    repeat (n) @(negedge clk);
    reset      = 1'b0;
    m_hi       = '0;
    m_lo       = '0;
    busy_until = 0;
    busy_q.delete();
  endtask

  function automatic logic [W-1:0] rand_operand();
    logic [W-1:0] v;
    case ($urandom_range(0, 5))
      0: v = '0;
      1: v = '1;
      2: v = 32'h8000_0000;
      3: v = W'($urandom_range(0, 20));
      4: v = -W'($urandom_range(1, 20));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // ---------------- monitor ----------------
  initial begin : monitor
    int srun;
    int brun;
    int e;
    logic [W-1:0] ev;
    srun = 0;
    brun = 0;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        srun = 0;
        brun = 0;
      end else begin
        if (busy) begin
          brun++;
        end else if (brun > 0) begin
          if (busy_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL busy_run: got %0d busy cycles, none expected", brun);
          end else begin
            e = busy_q.pop_front();
            check32("busy_cycles", W'(brun), W'(e));
          end
          brun = 0;
        end
        if (op_valid && tb_decoded(opcode, funct)) begin
          if (stall) begin
            srun++;
          end else begin
            if (stall_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL stall_q_empty: got accepted op, expected none");
            end else begin
              e = stall_q.pop_front();
              check32("stall_cycles", W'(srun), W'(e));
            end
            if (funct == T_MFHI || funct == T_MFLO) begin
              if (rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_q_empty: got mf read %h, expected none queued", hilo_rdata);
              end else begin
                ev = rd_q.pop_front();
                check32(funct == T_MFHI ? "mfhi_data" : "mflo_data", hilo_rdata, ev);
              end
            end
            srun = 0;
          end
        end else if (op_valid) begin
          check32("stall_unrelated", W'(stall), '0);
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish by 1000000, expected earlier");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int k;
    logic [W-1:0] a;
    logic [W-1:0] b;
    reset    = 1'b1;
    op_valid = 1'b0;
    opcode   = '0;
    funct    = '0;
    rs       = '0;
    rt       = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check32("reset_busy", W'(busy), '0);
    check32("reset_stall", W'(stall), '0);
    check32("reset_rdata", hilo_rdata, '0);
    check32("reset_state", W'(dbg_state), '0);
    issue(6'd0, T_MFHI, '0, '0);
    issue(6'd0, T_MFLO, '0, '0);

    // mt then mf
    issue(6'd0, T_MTLO, 32'h1234_5678, '0);
    issue(6'd0, T_MTHI, 32'hCAFE_F00D, '0);
    issue(6'd0, T_MFHI, '0, '0);
    issue(6'd0, T_MFLO, '0, '0);

    // directed mult/div, mf issued the very next cycle
    issue(6'd0, T_MULT, 32'hFFFF_FFFE, 32'd3);
    issue(6'd0, T_MFHI, '0, '0);
    issue(6'd0, T_MFLO, '0, '0);
    issue(6'd0, T_MULTU, 32'hFFFF_FFFE, 32'd3);
    issue(6'd0, T_MFHI, '0, '0);
    issue(6'd0, T_MFLO, '0, '0);
    issue(6'd0, T_DIV, 32'hFFFF_FFF9, 32'd2);
    issue(6'd0, T_MFLO, '0, '0);
    issue(6'd0, T_MFHI, '0, '0);
    issue(6'd0, T_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(6'd0, T_MFLO, '0, '0);
    issue(6'd0, T_MFHI, '0, '0);
    issue(6'd0, T_DIVU, 32'd100, 32'd0);
    issue(6'd0, T_MFLO, '0, '0);
    issue(6'd0, T_MFHI, '0, '0);
    issue(6'd0, T_DIV, 32'hFFFF_FFF9, 32'd0);
    issue(6'd0, T_MFHI, '0, '0);

    // unrelated instructions during busy
    issue(6'd0, T_MULT, 32'd7, 32'hFFFF_FFFB);
    issue(6'd0, T_ADD, 32'd1, 32'd2);
    issue(6'h08, T_MULT, 32'd1, 32'd2);
    idle(2);
    issue(6'd0, T_MFLO, '0, '0);
    issue(6'd0, T_MFHI, '0, '0);

    // reset on the 10th MUL cycle
    issue(6'd0, T_MTHI, 32'h5555_AAAA, '0);
    issue(6'd0, T_MULTU, 32'h0001_0001, 32'h0000_FFFF);
    idle(9);
    do_reset(1);
    #1;
    check32("abort_busy", W'(busy), '0);
    issue(6'd0, T_MFLO, '0, '0);
    issue(6'd0, T_MFHI, '0, '0);

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(0, 9);
      a = rand_operand();
      b = rand_operand();
      case (k)
        0: issue(6'd0, T_MULT, a, b);
        1: issue(6'd0, T_MULTU, a, b);
        2: issue(6'd0, T_DIV, a, b);
        3: issue(6'd0, T_DIVU, a, b);
        4: issue(6'd0, T_MTHI, a, b);
        5: issue(6'd0, T_MTLO, a, b);
        6: issue(6'd0, T_MFHI, a, b);
        7: issue(6'd0, T_MFLO, a, b);
        8: issue(6'd0, T_ADD, a, b);
        default: issue(6'h08, 6'($urandom_range(0, 63)), a, b);
      endcase
      if (k <= 3 && $urandom_range(0, 1) == 1) begin
        issue(6'd0, T_MFHI, '0, '0);
        issue(6'd0, T_MFLO, '0, '0);
      end
      idle($urandom_range(0, 2));
    end
    issue(6'd0, T_MFHI, '0, '0);
    issue(6'd0, T_MFLO, '0, '0);

    // drain
    n = 0;
    idle(1);
    while (busy && n < 200) begin
      idle(1);
      n++;
    end
    idle(2);
    check32("drain_busy", W'(busy), '0);
    check32("pending_q", W'(stall_q.size() + rd_q.size() + busy_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
